// File: rtl/carregador_programa_if.sv
// Host-side byte stream plus memory write / core control bundle for the nRisc boot loader.
// The loader is the slave; the host link (UART or bench) is the master.
interface carregador_programa_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        InByte;
    logic              InValid;
    logic              InReady;
    logic [ADDR_W-1:0] Endereco;
    logic [7:0]        DadoEscr;
    logic              InstrWrite;
    logic              DataWrite;
    logic              CpuReset;
    logic              Running;
    logic              Erro;
    logic [15:0]       Contagem;

    modport master (
        output InByte, InValid,
        input  InReady, Endereco, DadoEscr, InstrWrite, DataWrite,
        input  CpuReset, Running, Erro, Contagem
    );

    modport slave (
        input  InByte, InValid,
        output InReady, Endereco, DadoEscr, InstrWrite, DataWrite,
        output CpuReset, Running, Erro, Contagem
    );
endinterface

// File: rtl/carregador_programa.sv
// Boot loader for nRisc: decodes CMD/ADDR/LEN/payload frames from a byte stream into
// instruction/data memory writes, holding the core in reset until a RUN command.
module carregador_programa #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] CMD_INSTR = 8'hA1,
    parameter logic [7:0] CMD_DATA  = 8'hD1,
    parameter logic [7:0] CMD_RUN   = 8'h5A
) (
    input logic                   Clock,
    input logic                   Reset,
    carregador_programa_if.slave  bus
);

    typedef enum logic [2:0] {
        S_CMD, S_ADDR, S_LEN, S_DATA, S_RUN, S_ERR
    } state_t;

    typedef struct packed {
        logic              instr;
        logic              data;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        dado;
    } wr_t;

    state_t            state, state_nxt;
    logic              ready;
    logic              accept;
    logic              alvo_instr;
    logic [ADDR_W-1:0] addr_q;
    logic [8:0]        restante;
    logic [15:0]       contagem;
    wr_t               wr_q;

    assign ready  = (state == S_CMD) || (state == S_ADDR) ||
                    (state == S_LEN) || (state == S_DATA);
    assign accept = bus.InValid && ready;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_CMD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_CMD: begin
                if (accept) begin
                    if (bus.InByte == CMD_INSTR || bus.InByte == CMD_DATA) state_nxt = S_ADDR;
                    else if (bus.InByte == CMD_RUN)                        state_nxt = S_RUN;
                    else                                                   state_nxt = S_ERR;
                end
            end
            S_ADDR: if (accept) state_nxt = S_LEN;
            S_LEN:  if (accept) state_nxt = S_DATA;
            S_DATA: if (accept && restante == 9'd1) state_nxt = S_CMD;
            S_RUN:  state_nxt = S_RUN;
            S_ERR:  state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
    end

    // Strobes are single-cycle pulses; address/data registers hold between writes.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            alvo_instr <= 1'b0;
            addr_q     <= '0;
            restante   <= '0;
            contagem   <= '0;
            wr_q       <= '0;
        end else begin
            wr_q.instr <= 1'b0;
            wr_q.data  <= 1'b0;
            if (accept) begin
                case (state)
                    S_CMD:  alvo_instr <= (bus.InByte == CMD_INSTR);
                    S_ADDR: addr_q     <= ADDR_W'(bus.InByte);
                    S_LEN:  restante   <= (bus.InByte == 8'd0) ? 9'd256 : {1'b0, bus.InByte};
                    S_DATA: begin
                        wr_q.instr <= alvo_instr;
                        wr_q.data  <= !alvo_instr;
                        wr_q.addr  <= addr_q;
                        wr_q.dado  <= bus.InByte;
                        addr_q     <= addr_q + 1'b1;
                        restante   <= restante - 9'd1;
                        if (contagem != 16'hFFFF) contagem <= contagem + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.InReady    = ready;
    assign bus.Endereco   = wr_q.addr;
    assign bus.DadoEscr   = wr_q.dado;
    assign bus.InstrWrite = wr_q.instr;
    assign bus.DataWrite  = wr_q.data;
    assign bus.Contagem   = contagem;
    // Core control follows the state register, so RUN takes effect the cycle after acceptance.
    assign bus.CpuReset   = (state != S_RUN);
    assign bus.Running    = (state == S_RUN);
    assign bus.Erro       = (state == S_ERR);

endmodule
